// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60), per-axis phase encoding and the runtime config word
// used by the VGA sync sequencer.
package vga_timing_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    typedef enum logic [1:0] {
        PhActive = 2'd0,
        PhFront  = 2'd1,
        PhSync   = 2'd2,
        PhBack   = 2'd3
    } phase_e;

    typedef struct packed {
        logic hpol;
        logic vpol;
        logic video_en;
    } cfg_t;

    // Sync level for one axis: asserted level is the polarity bit itself.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// count_o/phase_o describe the pixel the sequencer will present on its next enabled edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CW     = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output phase_e        phase_o,
    output logic          wrap_o
);

    localparam int unsigned   Total     = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] EndActive = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] EndFront  = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] EndSync   = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] EndTotal  = CW'(Total - 1);

    logic [CW-1:0] count_q, count_d;
    phase_e        phase_q, phase_d;

    assign wrap_o  = inc_i && (count_q == EndTotal);
    assign count_o = count_q;
    assign phase_o = phase_q;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (inc_i) begin
            if (count_q == EndTotal) begin
                count_d = '0;
                phase_d = PhActive;
            end else begin
                count_d = count_q + 1'b1;
                if (count_q == EndActive) begin
                    phase_d = PhFront;
                end else if (count_q == EndFront) begin
                    phase_d = PhSync;
                end else if (count_q == EndSync) begin
                    phase_d = PhBack;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            phase_q <= PhActive;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_sync_sequencer.sv
// VGA timing master: drives registered sync/de/coordinates/pulses for one pixel per cycle and
// holds a one-deep config buffer that only takes effect at the start of a frame.
module vga_sync_sequencer
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          HPOL_RST = 1'b0,
    parameter bit          VPOL_RST = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cfg_valid,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    input  logic          cfg_video_en,
    output logic          cfg_ready,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam cfg_t RstCfg = '{hpol: HPOL_RST, vpol: VPOL_RST, video_en: 1'b1};

    logic [CW-1:0] h_count, v_count;
    phase_e        h_phase, v_phase;
    logic          h_wrap, v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (ena),
        .count_o (h_count),
        .phase_o (h_phase),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (ena && h_wrap),
        .count_o (v_count),
        .phase_o (v_phase),
        .wrap_o  (v_wrap)
    );

    cfg_t          active_q, active_d, pend_q, pend_d, cfg_in;
    logic          pend_valid_q, pend_valid_d;
    logic          origin_q, origin_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          xfer;

    assign cfg_in = '{hpol: cfg_hpol, vpol: cfg_vpol, video_en: cfg_video_en};
    assign xfer   = cfg_valid && !pend_valid_q && ena;

    // origin_q marks that the counters point at (0,0): the next enabled edge starts a frame,
    // so a pending config is promoted there and already governs pixel (0,0).
    always_comb begin
        active_d      = active_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        origin_d      = origin_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        if (ena && origin_q && pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
        end
        if (xfer) begin
            pend_d       = cfg_in;
            pend_valid_d = 1'b1;
        end

        if (ena) begin
            origin_d      = v_wrap;
            x_d           = h_count;
            y_d           = v_count;
            hsync_d       = sync_level(h_phase == PhSync, active_d.hpol);
            vsync_d       = sync_level(v_phase == PhSync, active_d.vpol);
            de_d          = (h_phase == PhActive) && (v_phase == PhActive) && active_d.video_en;
            line_start_d  = (h_count == '0);
            frame_start_d = origin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q      <= RstCfg;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            origin_q      <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HPOL_RST;
            vsync_q       <= ~VPOL_RST;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            origin_q      <= origin_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cfg_ready   = !pend_valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_sequencer.sv
// Directed bench: a default-timing instance checks reset and one full 800-pixel line, a
// shrunken-timing instance (16x12 totals) covers whole frames, config handshake and freezes.
module tb_vga_sync_sequencer;

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3, SHT = 16;
    localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 2, SVT = 12;
    localparam int SF  = SHT * SVT;
    localparam logic [27:0] RstVec = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n, ena, cfg_valid, cfg_hpol, cfg_vpol, cfg_video_en;

    logic       f_cfg_ready, f_hsync, f_vsync, f_de, f_line_start, f_frame_start;
    logic [9:0] f_x, f_y;
    logic       s_cfg_ready, s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
    logic [9:0] s_x, s_y;
    logic [27:0] f_vec, s_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_sync_sequencer u_full (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cfg_valid    (cfg_valid),
        .cfg_hpol     (cfg_hpol),
        .cfg_vpol     (cfg_vpol),
        .cfg_video_en (cfg_video_en),
        .cfg_ready    (f_cfg_ready),
        .hsync        (f_hsync),
        .vsync        (f_vsync),
        .de           (f_de),
        .x            (f_x),
        .y            (f_y),
        .line_start   (f_line_start),
        .frame_start  (f_frame_start)
    );

    vga_sync_sequencer #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .HPOL_RST (1'b0), .VPOL_RST (1'b0), .CW (10)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cfg_valid    (cfg_valid),
        .cfg_hpol     (cfg_hpol),
        .cfg_vpol     (cfg_vpol),
        .cfg_video_en (cfg_video_en),
        .cfg_ready    (s_cfg_ready),
        .hsync        (s_hsync),
        .vsync        (s_vsync),
        .de           (s_de),
        .x            (s_x),
        .y            (s_y),
        .line_start   (s_line_start),
        .frame_start  (s_frame_start)
    );

    assign f_vec = {f_x, f_y, f_de, f_hsync, f_vsync, f_line_start, f_frame_start, f_cfg_ready};
    assign s_vec = {s_x, s_y, s_de, s_hsync, s_vsync, s_line_start, s_frame_start, s_cfg_ready};

    // Reference model: {x, y, de, hsync, vsync, line_start, frame_start, cfg_ready}.
    function automatic logic [27:0] exp_vec(input int xx, input int yy, input int ha, input int hf,
                                            input int hs, input int va, input int vf, input int vs,
                                            input logic hp, input logic vp, input logic ve,
                                            input logic rdy);
        logic hin, vin, d;
        hin = (xx >= ha + hf) && (xx < ha + hf + hs);
        vin = (yy >= va + vf) && (yy < va + vf + vs);
        d   = (xx < ha) && (yy < va) && ve;
        return {10'(xx), 10'(yy), d, hin ? hp : ~hp, vin ? vp : ~vp, xx == 0,
                (xx == 0) && (yy == 0), rdy};
    endfunction

    function automatic logic [27:0] s_exp(input int k, input logic hp, input logic vp,
                                          input logic ve, input logic rdy);
        return exp_vec(k % SHT, (k / SHT) % SVT, SHA, SHF, SHS, SVA, SVF, SVS, hp, vp, ve, rdy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic v, input logic hp, input logic vp, input logic ve);
        cfg_valid    = v;
        cfg_hpol     = hp;
        cfg_vpol     = vp;
        cfg_video_en = ve;
    endtask

    task automatic wait_small(input int tx, input int ty);
        int n;
        n = 0;
        while (!(s_x == 10'(tx) && s_y == 10'(ty)) && n < 2 * SF) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 2 * SF) begin
            n_bad++;
            $display("FAIL wait_xy: position (%0d,%0d) never reached, required (%0d,%0d)",
                     s_x, s_y, tx, ty);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if (f_vec !== RstVec) begin
            n_bad++; $display("FAIL reset_full: got %h want %h", f_vec, RstVec);
        end
        n_cmp++;
        if (s_vec !== RstVec) begin
            n_bad++; $display("FAIL reset_small: got %h want %h", s_vec, RstVec);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (f_vec !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL release_full: got %h want %h", f_vec,
                              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        n_cmp++;
        if (s_vec !== s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            n_bad++; $display("FAIL release_small: got %h want %h", s_vec,
                              s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_line();
        logic [27:0] e;
        for (int i = 0; i < 800; i++) begin
            e = exp_vec(i, 0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (f_vec !== e) begin
                n_bad++; $display("FAIL line_full x=%0d: got %h want %h", i, f_vec, e);
            end
            tick();
        end
        e = exp_vec(0, 1, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (f_vec !== e) begin
            n_bad++; $display("FAIL line_wrap: got %h want %h", f_vec, e);
        end
    endtask

    task automatic test_frame();
        int vlow;
        vlow = 0;
        wait_small(0, 0);
        for (int k = 0; k < SF; k++) begin
            n_cmp++;
            if (s_vec !== s_exp(k, 1'b0, 1'b0, 1'b1, 1'b1)) begin
                n_bad++; $display("FAIL frame k=%0d: got %h want %h", k, s_vec,
                                  s_exp(k, 1'b0, 1'b0, 1'b1, 1'b1));
            end
            if (s_vsync == 1'b0) vlow++;
            tick();
        end
        n_cmp++;
        if (s_vec !== s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            n_bad++; $display("FAIL frame_period: got %h want %h", s_vec,
                              s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        n_cmp++;
        if (vlow != SVS * SHT) begin
            n_bad++; $display("FAIL vsync_width: got %0d want %0d", vlow, SVS * SHT);
        end
    endtask

    task automatic test_cfg();
        wait_small(0, 3);
        set_cfg(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        // A second word offered while busy must be ignored.
        set_cfg(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 3 * SHT + 1; k < SF; k++) begin
            n_cmp++;
            if (s_vec !== s_exp(k, 1'b0, 1'b0, 1'b1, 1'b0)) begin
                n_bad++; $display("FAIL cfg_hold k=%0d: got %h want %h", k, s_vec,
                                  s_exp(k, 1'b0, 1'b0, 1'b1, 1'b0));
            end
            if (k == 3 * SHT + 5) cfg_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < SF; k++) begin
            n_cmp++;
            if (s_vec !== s_exp(k, 1'b1, 1'b1, 1'b0, 1'b1)) begin
                n_bad++; $display("FAIL cfg_applied k=%0d: got %h want %h", k, s_vec,
                                  s_exp(k, 1'b1, 1'b1, 1'b0, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_wrap_xfer();
        wait_small(SHT - 1, SVT - 1);
        n_cmp++;
        if (s_vec !== s_exp(SF - 1, 1'b1, 1'b1, 1'b0, 1'b1)) begin
            n_bad++; $display("FAIL wrap_pre: got %h want %h", s_vec,
                              s_exp(SF - 1, 1'b1, 1'b1, 1'b0, 1'b1));
        end
        set_cfg(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < SF; k++) begin
            n_cmp++;
            if (s_vec !== s_exp(k, 1'b1, 1'b1, 1'b0, 1'b0)) begin
                n_bad++; $display("FAIL wrap_deferred k=%0d: got %h want %h", k, s_vec,
                                  s_exp(k, 1'b1, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        n_cmp++;
        if (s_vec !== s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            n_bad++; $display("FAIL wrap_applied: got %h want %h", s_vec,
                              s_exp(0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_ena();
        wait_small(5, 2);
        ena = 1'b0;
        set_cfg(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (s_vec !== s_exp(2 * SHT + 5, 1'b0, 1'b0, 1'b1, 1'b1)) begin
                n_bad++; $display("FAIL freeze i=%0d: got %h want %h", i, s_vec,
                                  s_exp(2 * SHT + 5, 1'b0, 1'b0, 1'b1, 1'b1));
            end
        end
        ena = 1'b1;
        cfg_valid = 1'b0;
        tick();
        n_cmp++;
        if (s_vec !== s_exp(2 * SHT + 6, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            n_bad++; $display("FAIL resume: got %h want %h", s_vec,
                              s_exp(2 * SHT + 6, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_reset_pending();
        set_cfg(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        cfg_valid = 1'b0;
        n_cmp++;
        if (s_vec !== s_exp(2 * SHT + 7, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL pend_taken: got %h want %h", s_vec,
                              s_exp(2 * SHT + 7, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (s_vec !== RstVec) begin
            n_bad++; $display("FAIL reset_pend: got %h want %h", s_vec, RstVec);
        end
        n_cmp++;
        if (f_vec !== RstVec) begin
            n_bad++; $display("FAIL reset_mid_full: got %h want %h", f_vec, RstVec);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= SF; k++) begin
            tick();
            n_cmp++;
            if (s_vec !== s_exp(k % SF, 1'b0, 1'b0, 1'b1, 1'b1)) begin
                n_bad++; $display("FAIL no_residue k=%0d: got %h want %h", k, s_vec,
                                  s_exp(k % SF, 1'b0, 1'b0, 1'b1, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_cfg();
        test_wrap_xfer();
        test_ena();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
